dual_stream_gen: RTL and testbench
==================================

DUAL_STREAM_GEN -- requirements
Module: dual_stream_gen

Interface
REQ-001 Parameter WIDTH, default 8: binary operand precision; stream length is 2^WIDTH beats.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clr  input  1  synchronous abort; returns the block to IDLE.
REQ-005 in_valid  input  1  operand load request.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 in0_bin  input  WIDTH  unsigned binary value for stream 0.
REQ-008 in1_bin  input  WIDTH  unsigned binary value for stream 1.
REQ-009 corr  input  1  1 = positively correlated streams (shared random number), 0 = decorrelated.
REQ-010 out0  output  1  stream 0 bit, feeds downstream skew synchronizer input 0.
REQ-011 out1  output  1  stream 1 bit, feeds downstream skew synchronizer input 1.
REQ-012 out_valid  output  1  out0/out1 carry a valid beat.
REQ-013 out_ready  input  1  downstream accepts the current beat.
REQ-014 out_last  output  1  current beat is the final beat of the stream.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-016 In IDLE, in_ready SHALL be 1, and out_valid, out0, out1, out_last SHALL be 0.
REQ-017 In IDLE with in_valid=1 and clr=0, the block SHALL latch in0_bin, in1_bin, corr, clear the beat counter to 0, and enter RUN next cycle.
REQ-018 In RUN, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-019 In RUN, out_valid SHALL be 1; out0 = (in0_q > cnt); out1 = (in1_q > r1), where r1 = cnt if corr_q=1, else bit-reversed cnt; unsigned WIDTH-bit compares.
REQ-020 Outputs SHALL be combinational from registered state only (no combinational path from in0_bin/in1_bin/out_ready to out0/out1).
REQ-021 The counter SHALL advance by 1 only on a handshake (out_valid & out_ready); without out_ready, out0/out1/out_last SHALL hold.
REQ-022 out_last SHALL be 1 when in RUN and cnt = 2^WIDTH-1.
REQ-023 A handshake with out_last=1 SHALL return the FSM to IDLE next cycle; the counter SHALL NOT wrap into a second stream.
REQ-024 Over one complete stream, out0 SHALL contain exactly in0_bin ones and out1 exactly in1_bin ones, for either corr value.
REQ-025 With corr=1, out0=1 SHALL imply out1=1 whenever in0_bin <= in1_bin (maximal overlap).
REQ-026 clr=1 SHALL force IDLE on the next edge from any state; clr SHALL take priority over in_valid and over a concurrent final handshake.
REQ-027 in0_bin=0 SHALL yield an all-zero stream of full length, with out_last still asserted on beat 2^WIDTH-1.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, counter 0, latched operands 0, corr_q 0.
REQ-029 During and immediately after reset: in_ready=1, out_valid=0, out0=0, out1=0, out_last=0.
REQ-030 Reset asserted mid-stream SHALL discard the stream; no partial beats SHALL appear after release.

Structure
REQ-031 A shared package SHALL hold the FSM state typedef (IDLE, RUN) and a bit-reverse function parameterised on WIDTH.
REQ-032 One sub-module, unary_cmp (WIDTH-bit value vs random number -> 1 bit), SHALL be instantiated twice.

Verification (WIDTH=4, 16-beat streams)
REQ-033 in0=5, in1=12, corr=1, out_ready=1 -> out0=1 on beats 0-4, out1=1 on beats 0-11; out_last on beat 15; IDLE on the following cycle.
REQ-034 in0=4, in1=8, corr=0 -> out1=1 exactly on even beats (8 ones); out0 has 4 ones on beats 0-3.
REQ-035 out_ready=0 for 2 cycles at beat 3 -> beat-3 bits held 3 cycles; still exactly 16 accepted beats with correct ones counts.
REQ-036 clr pulsed at beat 7 -> out_valid=0 and in_ready=1 next cycle; a new load then starts at beat 0.
REQ-037 rst_n low at beat 9, released 2 cycles later -> all outputs 0, in_ready=1, no further beats until a new load.
REQ-038 in0=0, in1=15, corr=0 -> out0 all zero, out1 15 ones with out1=0 only on beat 15; out_last asserted on beat 15.

Source files
------------

// File: rtl/dual_stream_gen_pkg.sv
// Shared types and helpers for the dual stochastic stream generator.
//   state_t  : two-state controller encoding (IDLE, RUN)
//   bit_rev  : reverses the low 'width' bits of a value; the result is
//              right-aligned, so callers truncate to their own width.
package dual_stream_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_WIDTH = 32;

    // Full-width reversal followed by a right shift.
    // This keeps every bit index constant, so the loop maps onto plain wiring.
    function automatic logic [MAX_WIDTH-1:0] bit_rev(
        input logic [MAX_WIDTH-1:0] value,
        input int unsigned          width
    );
        logic [MAX_WIDTH-1:0] full;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            full[MAX_WIDTH-1-i] = value[i];
        end
        return full >> (MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/dual_stream_gen_unary_cmp.sv
// Unary (stochastic) bit generator: one beat of a stream is 1 when the
// binary operand exceeds the per-beat random number.
//   value : WIDTH-bit unsigned operand
//   rnd   : WIDTH-bit random/sequence number for this beat
//   gt    : value > rnd
module unary_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] rnd,
    output logic             gt
);

    assign gt = (value > rnd);

endmodule

// File: rtl/dual_stream_gen.sv
// Dual stochastic stream generator. Latches two binary operands and emits
// 2^WIDTH beats per stream on a valid/ready interface. Stream 0 compares
// against the beat count. Stream 1 compares against either the same count
// (correlated) or the bit-reversed count (decorrelated).
//   clk, rst_n          : clock, async active-low reset
//   clr                 : synchronous abort back to IDLE
//   in_valid / in_ready : operand load handshake (in0_bin, in1_bin, corr)
//   out_valid/out_ready : beat handshake; out0/out1 are the stream bits
//   out_last            : final beat (count = 2^WIDTH-1)
//
// state | meaning
// IDLE  | waiting for an operand load; outputs quiet, in_ready=1
// RUN   | streaming beats; the counter advances on each accepted beat
module dual_stream_gen
    import dual_stream_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0_bin,
    input  logic [WIDTH-1:0] in1_bin,
    input  logic             corr,
    output logic             out0,
    output logic             out1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nx;
    logic [WIDTH-1:0] in0_q;
    logic [WIDTH-1:0] in1_q;
    logic             corr_q;
    logic             load;
    logic [WIDTH-1:0] cnt_rev;
    logic [WIDTH-1:0] rnd1;
    logic             gt0;
    logic             gt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            in0_q  <= '0;
            in1_q  <= '0;
            corr_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (load) begin
                in0_q  <= in0_bin;
                in1_q  <= in1_bin;
                corr_q <= corr;
            end
        end
    end

    // clr is tested first in both states so it wins over a load request
    // and over a final-beat handshake.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (clr) begin
                    cnt_nx = '0;
                end else if (in_valid) begin
                    load     = 1'b1;
                    cnt_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                out_last  = (cnt == CNT_MAX);
                if (clr) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (out_ready) begin
                    if (out_last) begin
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // The bit-reversed count visits every value once per stream, like the
    // plain count, but it is spread out. This decorrelates the two streams
    // while each stream still keeps an exact ones count.
    assign cnt_rev = WIDTH'(bit_rev(MAX_WIDTH'(cnt), WIDTH));
    assign rnd1    = corr_q ? cnt : cnt_rev;

    unary_cmp #(.WIDTH(WIDTH)) u_cmp0 (
        .value (in0_q),
        .rnd   (cnt),
        .gt    (gt0)
    );

    unary_cmp #(.WIDTH(WIDTH)) u_cmp1 (
        .value (in1_q),
        .rnd   (rnd1),
        .gt    (gt1)
    );

    assign out0 = out_valid & gt0;
    assign out1 = out_valid & gt1;

endmodule

// File: tb/tb_dual_stream_gen.sv
// Directed bench for dual_stream_gen at WIDTH=4 (16-beat streams).
module tb_dual_stream_gen;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in0_bin;
    logic [W-1:0] in1_bin;
    logic         corr;
    logic         out0;
    logic         out1;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dual_stream_gen #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0_bin   (in0_bin),
        .in1_bin   (in1_bin),
        .corr      (corr),
        .out0      (out0),
        .out1      (out1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        in0_bin  = a;
        in1_bin  = b;
        corr     = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Loads operands and collects one whole stream. The stream is checked
    // against hand-computed beat masks. With 'poke' set, in_valid is held
    // high with garbage operands mid-stream; RUN must ignore it.
    task automatic run_stream(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c, input logic [15:0] m0, input logic [15:0] m1,
                              input int stall_beat, input bit poke);
        logic [15:0] g0;
        logic [15:0] g1;
        logic [15:0] gl;
        int          n_hs;
        int          budget;
        g0     = '0;
        g1     = '0;
        gl     = '0;
        n_hs   = 0;
        budget = 0;
        load(a, b, c);
        while (n_hs < 16 && budget < 64) begin
            budget++;
            if (poke) begin
                in_valid = (n_hs >= 1 && n_hs <= 10);
                in0_bin  = 4'hF;
                in1_bin  = 4'h0;
                corr     = ~c;
            end
            if (out_valid !== 1'b1) begin
                check({tag, " valid_beat"}, 32'(out_valid), 32'd1);
                break;
            end
            g0[n_hs] = out0;
            g1[n_hs] = out1;
            gl[n_hs] = out_last;
            if (n_hs == stall_beat) begin
                out_ready = 1'b0;
                repeat (2) begin
                    tick();
                    check({tag, " hold"}, {28'd0, out_valid, out0, out1, out_last},
                          {28'd0, 1'b1, m0[n_hs], m1[n_hs], 1'b0});
                end
                out_ready = 1'b1;
            end
            tick();
            n_hs++;
        end
        if (poke) in_valid = 1'b0;
        check({tag, " beats"}, 32'(n_hs), 32'd16);
        check({tag, " out0"}, 32'(g0), 32'(m0));
        check({tag, " out1"}, 32'(g1), 32'(m1));
        check({tag, " last"}, 32'(gl), 32'h8000);
        check({tag, " ones0"}, 32'($countones(g0)), 32'(a));
        check({tag, " ones1"}, 32'($countones(g1)), 32'(b));
        check({tag, " idle_after"}, {30'd0, out_valid, in_ready}, 32'b01);
        tick();
        check({tag, " no_wrap"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        corr      = 1'b0;
        in0_bin   = '0;
        in1_bin   = '0;
        #3;
        check("reset_during", {27'd0, in_ready, out_valid, out0, out1, out_last}, 32'b10000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("reset_after", {27'd0, in_ready, out_valid, out0, out1, out_last}, 32'b10000);

        // correlated, maximal overlap
        run_stream("s_corr_5_12", 4'd5, 4'd12, 1'b1, 16'h001F, 16'h0FFF, -1, 1'b0);
        // decorrelated: 8 > rev(cnt) exactly on even beats
        run_stream("s_dec_4_8", 4'd4, 4'd8, 1'b0, 16'h000F, 16'h5555, -1, 1'b0);
        // decorrelated: 3 > rev(cnt) on beats 0, 8, 4
        run_stream("s_dec_10_3", 4'd10, 4'd3, 1'b0, 16'h03FF, 16'h0111, -1, 1'b0);
        // backpressure at beat 3, with in_valid noise during RUN
        run_stream("s_stall", 4'd6, 4'd9, 1'b1, 16'h003F, 16'h01FF, 3, 1'b1);
        // zero operand still runs the full length
        run_stream("s_zero", 4'd0, 4'd15, 1'b0, 16'h0000, 16'h7FFF, -1, 1'b0);

        // clr mid-stream at beat 7
        load(4'd7, 4'd7, 1'b1);
        repeat (7) tick();
        check("clr_beat7", {28'd0, out_valid, out0, out1, out_last}, 32'b1000);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_idle", {30'd0, out_valid, in_ready}, 32'b01);
        run_stream("s_after_clr", 4'd2, 4'd14, 1'b1, 16'h0003, 16'h3FFF, -1, 1'b0);

        // clr beats a concurrent final handshake and in_valid
        load(4'd15, 4'd15, 1'b1);
        repeat (15) tick();
        check("clr_last_beat", {30'd0, out_valid, out_last}, 32'b11);
        clr      = 1'b1;
        in_valid = 1'b1;
        tick();
        check("clr_over_last", {30'd0, out_valid, in_ready}, 32'b01);
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_over_load", {30'd0, out_valid, in_ready}, 32'b01);
        tick();
        check("clr_stays_idle", {30'd0, out_valid, in_ready}, 32'b01);

        // async reset mid-stream at beat 9
        load(4'd9, 4'd9, 1'b0);
        repeat (9) tick();
        check("rst_beat9", {30'd0, out_valid, out_last}, 32'b10);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_during", {27'd0, in_ready, out_valid, out0, out1, out_last}, 32'b10000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_mid_release", {27'd0, in_ready, out_valid, out0, out1, out_last}, 32'b10000);
        repeat (3) tick();
        check("rst_mid_quiet", {27'd0, in_ready, out_valid, out0, out1, out_last}, 32'b10000);
        run_stream("s_after_rst", 4'd1, 4'd1, 1'b0, 16'h0001, 16'h0001, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
